avr_prefetch_queue: RTL and testbench

//  Instruction prefetch queue between program memory and avr_fetch. Issues sequential

---
 rtl/avr_prefetch_queue.sv | 106 ++++++++++
 tb/tb_avr_prefetch_queue.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential program-memory reads, buffers the
// returned words with their addresses and presents them to avr_fetch in order.
module avr_prefetch_queue #(
    parameter int            AW       = 9,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [15:0]   mem_rdata,
    output logic          instr_valid,
    output logic [15:0]   instr,
    output logic [AW-1:0] instr_addr,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   word;
    } entry_t;

    entry_t        queue [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [AW-1:0] issue_pc;
    logic [AW-1:0] resp_pc;

    logic [CW:0]   occupancy;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;

    // Queued words plus outstanding reads never exceed DEPTH, so a push always has room.
    always_comb begin
        occupancy   = {1'b0, count} + {1'b0, inflight};
        mem_req     = !RST && !redirect && (occupancy < DEPTH_C);
        mem_addr    = issue_pc;
        grant       = mem_req && mem_gnt;
        rsp         = mem_rvalid && (inflight != '0);
        push        = rsp && (drop == '0);
        instr_valid = (count != '0);
        pop         = instr_valid && instr_ready;
        instr       = queue[head].word;
        instr_addr  = queue[head].addr;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            issue_pc <= redirect_addr;
            resp_pc  <= redirect_addr;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            // Every outstanding response is now stale, including ones already marked
            // for discard; a response arriving this cycle is consumed here.
            inflight <= inflight - CW'(rsp);
            drop     <= inflight - CW'(rsp);
        end else begin
            if (grant) begin
                issue_pc <= issue_pc + 1'b1;
            end
            inflight <= inflight + CW'(grant) - CW'(rsp);
            if (rsp && (drop != '0)) begin
                drop <= drop - 1'b1;
            end
            if (push) begin
                tail    <= tail + 1'b1;
                resp_pc <= resp_pc + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge CLK) begin
        if (push) begin
            queue[tail] <= '{addr: resp_pc, word: mem_rdata};
        end
    end

endmodule

// File: tb/tb_avr_prefetch_queue.sv
// Directed and randomized bench for avr_prefetch_queue with an in-order
// variable-latency program-memory model and an address/data scoreboard.
module tb_avr_prefetch_queue;

    localparam int AW    = 9;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b1;
    logic          mem_rvalid = 1'b0;
    logic [15:0]   mem_rdata = 16'h0000;
    logic          instr_valid;
    logic [15:0]   instr;
    logic [AW-1:0] instr_addr;
    logic          instr_ready = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;

    avr_prefetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .CLK(CLK), .RST(RST),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } req_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   word;
        logic [AW-1:0] exp;
    } pop_t;

    req_t          pend[$];
    pop_t          pops[$];
    logic [AW-1:0] gnt_log[$];

    int            cyc = 0;
    int            lat_min = 1;
    int            lat_max = 1;
    bit            gnt_rand = 1'b0;
    int            max_pend = 0;
    int            hold_err = 0;
    logic          prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] exp_addr = '0;

    int            checks = 0;
    int            errors = 0;

    function automatic logic [15:0] pmem(input logic [AW-1:0] a);
        return 16'hA000 + {7'd0, a};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Decisions made here take effect at the next rising edge.
    always @(negedge CLK) begin
        if (RST) begin
            exp_addr = '0;
        end else if (redirect) begin
            exp_addr = redirect_addr;
        end else if (instr_valid && instr_ready) begin
            pops.push_back('{instr_addr, instr, exp_addr});
            exp_addr = exp_addr + 1'b1;
        end
        if (prev_wait && !RST && !redirect && (!mem_req || mem_addr !== prev_addr)) begin
            hold_err++;
        end
        if (RST) begin
            pend.delete();
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b1;
            prev_wait  = 1'b0;
        end else begin
            mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pmem(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 16'hDEAD;
            end
            if (mem_req && mem_gnt) begin
                pend.push_back('{mem_addr, cyc + 1 + int'($urandom_range(lat_min, lat_max))});
                gnt_log.push_back(mem_addr);
            end
            if (pend.size() > max_pend) max_pend = pend.size();
            prev_wait = mem_req && !mem_gnt;
            prev_addr = mem_addr;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST      = 1'b1;
        redirect = 1'b0;
        tick;
        tick;
        RST = 1'b0;
        pops.delete();
        gnt_log.delete();
    endtask

    task automatic test_reset;
        lat_min = 1; lat_max = 1; gnt_rand = 1'b0; instr_ready = 1'b1;
        RST = 1'b1;
        tick;
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
        tick;
        RST = 1'b0;
        pops.delete();
        gnt_log.delete();
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 9'h000) begin
            errors++; $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=000", mem_req, mem_addr);
        end
    endtask

    task automatic test_stream;
        tick;
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== 9'h001) begin
            errors++; $display("FAIL stream_e1 got valid=%b addr=%h want valid=0 addr=001", instr_valid, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'hA000 + 16'(i) || instr_addr !== 9'(i)) begin
                errors++;
                $display("FAIL stream_word%0d got valid=%b instr=%h addr=%h want valid=1 instr=%h addr=%h",
                         i, instr_valid, instr, instr_addr, 16'hA000 + 16'(i), 9'(i));
            end
        end
    endtask

    task automatic test_backpressure;
        lat_min = 1; lat_max = 1; gnt_rand = 1'b0;
        instr_ready = 1'b0;
        do_reset;
        repeat (10) tick;
        checks++;
        if (gnt_log.size() !== DEPTH) begin errors++; $display("FAIL bp_issued got %0d want %0d", gnt_log.size(), DEPTH); end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low got %b want 0", mem_req); end
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 9'h000 || instr !== 16'hA000) begin
            errors++; $display("FAIL bp_head got valid=%b addr=%h instr=%h want 1 000 A000", instr_valid, instr_addr, instr);
        end
        instr_ready = 1'b1;
        repeat (16) tick;
        checks++;
        if (pops.size() < 12) begin errors++; $display("FAIL bp_pop_count got %0d want >=12", pops.size()); end
        for (int i = 0; i < 4 && i < pops.size(); i++) begin
            checks++;
            if (pops[i].addr !== 9'(i) || pops[i].word !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL bp_order%0d got addr=%h instr=%h want %h %h",
                                   i, pops[i].addr, pops[i].word, 9'(i), 16'hA000 + 16'(i));
            end
        end
        for (int i = 0; i < gnt_log.size(); i++) begin
            checks++;
            if (gnt_log[i] !== 9'(i)) begin
                errors++; $display("FAIL bp_issue_seq%0d got %h want %h", i, gnt_log[i], 9'(i));
            end
        end
    endtask

    task automatic test_redirect_inflight;
        lat_min = 3; lat_max = 3; gnt_rand = 1'b0; instr_ready = 1'b1;
        do_reset;
        repeat (3) tick;
        redirect      = 1'b1;
        redirect_addr = 9'h040;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rdi_req got %b want 0", mem_req); end
        tick;
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdi_valid got %b want 0", instr_valid); end
        repeat (14) tick;
        checks++;
        if (pops.size() < 3) begin
            errors++; $display("FAIL rdi_pop_count got %0d want >=3", pops.size());
        end else begin
            checks++;
            if (pops[0].addr !== 9'h040 || pops[0].word !== 16'hA040) begin
                errors++; $display("FAIL rdi_first got addr=%h instr=%h want 040 A040", pops[0].addr, pops[0].word);
            end
            checks++;
            if (pops[1].addr !== 9'h041 || pops[1].word !== 16'hA041) begin
                errors++; $display("FAIL rdi_second got addr=%h instr=%h want 041 A041", pops[1].addr, pops[1].word);
            end
        end
    endtask

    task automatic test_redirect_collision;
        lat_min = 1; lat_max = 1; gnt_rand = 1'b0; instr_ready = 1'b1;
        do_reset;
        repeat (3) tick;
        checks++;
        if (pops.size() !== 1 || instr_valid !== 1'b1 || instr_addr !== 9'h001) begin
            errors++; $display("FAIL rdc_pre got pops=%0d valid=%b addr=%h want 1 1 001", pops.size(), instr_valid, instr_addr);
        end
        redirect      = 1'b1;
        redirect_addr = 9'h100;
        tick;
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pops.size() !== 1) begin
            errors++; $display("FAIL rdc_flush got valid=%b pops=%0d want 0 1", instr_valid, pops.size());
        end
        tick;
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdc_e5 got %b want 0", instr_valid); end
        tick;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'hA100 || instr_addr !== 9'h100) begin
            errors++; $display("FAIL rdc_first got valid=%b instr=%h addr=%h want 1 A100 100", instr_valid, instr, instr_addr);
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_a [4];
        exp_a = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        redirect      = 1'b1;
        redirect_addr = 9'h1FE;
        tick;
        redirect = 1'b0;
        pops.delete();
        repeat (8) tick;
        checks++;
        if (pops.size() < 4) begin
            errors++; $display("FAIL wrap_count got %0d want >=4", pops.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pops[i].addr !== exp_a[i] || pops[i].word !== pmem(exp_a[i])) begin
                    errors++; $display("FAIL wrap%0d got addr=%h instr=%h want %h %h",
                                       i, pops[i].addr, pops[i].word, exp_a[i], pmem(exp_a[i]));
                end
            end
        end
    endtask

    task automatic test_random;
        lat_min = 1; lat_max = 4; gnt_rand = 1'b1;
        do_reset;
        max_pend = 0;
        hold_err = 0;
        for (int c = 0; c < 2000; c++) begin
            instr_ready   = 1'($urandom_range(0, 1));
            redirect      = ($urandom_range(0, 39) == 0);
            redirect_addr = 9'($urandom_range(0, 511));
            tick;
        end
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (20) tick;
        checks++;
        if (pops.size() < 200) begin errors++; $display("FAIL rnd_progress got %0d want >=200", pops.size()); end
        for (int i = 0; i < pops.size(); i++) begin
            checks++;
            if (pops[i].addr !== pops[i].exp || pops[i].word !== pmem(pops[i].exp)) begin
                errors++; $display("FAIL rnd_pop%0d got addr=%h instr=%h want %h %h",
                                   i, pops[i].addr, pops[i].word, pops[i].exp, pmem(pops[i].exp));
            end
        end
        checks++;
        if (max_pend > DEPTH) begin errors++; $display("FAIL rnd_inflight got %0d want <=%0d", max_pend, DEPTH); end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL rnd_req_hold got %0d want 0", hold_err); end
    endtask

    task automatic test_mid_reset;
        lat_min = 1; lat_max = 1; gnt_rand = 1'b0; instr_ready = 1'b1;
        repeat (5) tick;
        RST = 1'b1;
        tick;
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL mrst_state got valid=%b req=%b want 0 0", instr_valid, mem_req);
        end
        RST = 1'b0;
        tick;
        tick;
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 9'h000 || instr !== 16'hA000) begin
            errors++; $display("FAIL mrst_restart got valid=%b addr=%h instr=%h want 1 000 A000", instr_valid, instr_addr, instr);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_inflight;
        test_redirect_collision;
        test_wrap;
        test_random;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
